// File: rtl/reg_file_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wr_arb
// Purpose  : Two-requester write-port arbiter for the 32x32 register file.
//            Optional build macro RF_WR_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_wr_arb #(
    parameter int N_REQ     = 2,
    parameter bit X0_FILTER = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [4:0]         req_reg_0,
    input  logic [31:0]        req_data_0,
    input  logic [4:0]         req_reg_1,
    input  logic [31:0]        req_data_1,
    output logic               wr_en,
    output logic [4:0]         wr_reg,
    output logic [31:0]        wr_data,
    output logic               inflight_valid,
    output logic [4:0]         inflight_reg,
    output logic               grant_last
);

    logic [1:0]  w_ready;
    logic        w_transfer;
    logic        w_winner;
    logic [4:0]  w_sel_reg;
    logic [31:0] w_sel_data;

    logic        r_wr_en;
    logic [4:0]  r_wr_reg;
    logic [31:0] r_wr_data;
    logic        r_grant_last;

    // Grant is forced low during reset so no handshake can complete then.
    always_comb begin
        w_ready = 2'b00;
        if (!rst) begin
            case (req_valid)
                2'b01:   w_ready = 2'b01;
                2'b10:   w_ready = 2'b10;
`ifdef RF_WR_ARB_FIXED_PRIO_EN
                2'b11:   w_ready = 2'b01;
`else
                2'b11:   w_ready = r_grant_last ? 2'b01 : 2'b10;
`endif
                default: w_ready = 2'b00;
            endcase
        end
    end

    assign w_transfer = |(req_valid & w_ready);
    assign w_winner   = w_ready[1];
    assign w_sel_reg  = w_winner ? req_reg_1  : req_reg_0;
    assign w_sel_data = w_winner ? req_data_1 : req_data_0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en      <= 1'b0;
            r_wr_reg     <= 5'd0;
            r_wr_data    <= 32'd0;
            r_grant_last <= 1'b1;
        end else begin
            r_wr_en <= w_transfer && !(X0_FILTER && (w_sel_reg == 5'd0));
            if (w_transfer) begin
                r_wr_reg     <= w_sel_reg;
                r_wr_data    <= w_sel_data;
                r_grant_last <= w_winner;
            end
        end
    end

    assign req_ready      = w_ready;
    assign wr_en          = r_wr_en;
    assign wr_reg         = r_wr_reg;
    assign wr_data        = r_wr_data;
    assign inflight_valid = r_wr_en;
    assign inflight_reg   = r_wr_reg;
    assign grant_last     = r_grant_last;

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
    a_ready_needs_valid : assert property (@(posedge clk) disable iff (rst)
        ((req_ready & ~req_valid) == '0));
    a_no_x0_write : assert property (@(posedge clk) disable iff (rst)
        wr_en |-> (!X0_FILTER || (wr_reg != 5'd0)));
    a_wr_en_from_transfer : assert property (@(posedge clk) disable iff (rst)
        wr_en |-> $past(w_transfer));
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wr_arb
// Purpose  : Directed scoreboard bench for reg_file_wr_arb with a bench-owned
//            register file fed by wr_en/wr_reg/wr_data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_wr_arb;

    localparam bit c_X0F = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [4:0]  req_reg_0 = '0, req_reg_1 = '0;
    logic [31:0] req_data_0 = '0, req_data_1 = '0;
    logic        wr_en, inflight_valid, grant_last;
    logic [4:0]  wr_reg, inflight_reg;
    logic [31:0] wr_data;

    typedef struct packed {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        gl;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        m_gl   = 1'b1;
    logic [4:0]  m_reg  = '0;
    logic [31:0] m_data = '0;
    logic [1:0]  p_pend = 2'b00;
    logic [31:0] rf [32];

    reg_file_wr_arb #(.N_REQ(2), .X0_FILTER(c_X0F)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_reg_0      (req_reg_0),
        .req_data_0     (req_data_0),
        .req_reg_1      (req_reg_1),
        .req_data_1     (req_data_1),
        .wr_en          (wr_en),
        .wr_reg         (wr_reg),
        .wr_data        (wr_data),
        .inflight_valid (inflight_valid),
        .inflight_reg   (inflight_reg),
        .grant_last     (grant_last)
    );

    always #5 clk = ~clk;

    // Register file downstream of the arbiter; x0 is hardwired to zero.
    always @(posedge clk) begin
        if (wr_en && (wr_reg != 5'd0))
            rf[wr_reg] <= wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_ready(input logic [1:0] v, input logic gl);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
`ifdef RF_WR_ARB_FIXED_PRIO_EN
            2'b11:   return 2'b01;
`else
            2'b11:   return gl ? 2'b01 : 2'b10;
`endif
            default: return 2'b00;
        endcase
    endfunction

    task automatic step(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                        input logic [4:0] r1, input logic [31:0] d1);
        logic [1:0]  er;
        logic [4:0]  sr;
        exp_t        e;
        @(negedge clk);
        req_valid  = v;
        req_reg_0  = r0;
        req_data_0 = d0;
        req_reg_1  = r1;
        req_data_1 = d1;
        #1;
        chk("protocol_valid_hold", 64'(p_pend & ~v), 64'd0);
        er = exp_ready(v, m_gl);
        chk("req_ready", 64'(req_ready), 64'(er));
        if (er != 2'b00) begin
            sr     = er[1] ? r1 : r0;
            m_reg  = sr;
            m_data = er[1] ? d1 : d0;
            m_gl   = er[1];
            e.en   = !(c_X0F && (sr == 5'd0));
        end else begin
            e.en   = 1'b0;
        end
        p_pend = v & ~er;
        e.rg   = m_reg;
        e.data = m_data;
        e.gl   = m_gl;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("wr_en",          64'(wr_en),          64'(e.en));
        chk("wr_reg",         64'(wr_reg),         64'(e.rg));
        chk("wr_data",        64'(wr_data),        64'(e.data));
        chk("grant_last",     64'(grant_last),     64'(e.gl));
        chk("inflight_valid", 64'(inflight_valid), 64'(e.en));
        chk("inflight_reg",   64'(inflight_reg),   64'(e.rg));
    endtask

    initial begin
        int i0, i1;
        for (int k = 0; k < 32; k++) rf[k] = 32'd0;

        // Reset with both requesters shouting: nothing may be granted.
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",      64'(req_ready),  64'd0);
        chk("rst_wr_en",      64'(wr_en),      64'd0);
        chk("rst_wr_reg",     64'(wr_reg),     64'd0);
        chk("rst_wr_data",    64'(wr_data),    64'd0);
        chk("rst_grant_last", 64'(grant_last), 64'd1);
        req_valid = 2'b00;
        rst = 1'b0;

        repeat (5) step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        // Single write, then commit one edge later.
        step(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("rf_x5", 64'(rf[5]), 64'hDEADBEEF);

        // Continuous contention until both queues drain.
        i0 = 0;
        i1 = 0;
        while (i0 < 4 || i1 < 4) begin
            logic [1:0] v;
            logic [1:0] er;
            v  = {i1 < 4, i0 < 4};
            er = exp_ready(v, m_gl);
            step(v, 5'(1 + i0), 32'(32'h10 + i0), 5'(11 + i1), 32'(32'h20 + i1));
            if (er[0]) i0++;
            if (er[1]) i1++;
        end
        step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("rf_x1",  64'(rf[1]),  64'h10);
        chk("rf_x4",  64'(rf[4]),  64'h13);
        chk("rf_x11", 64'(rf[11]), 64'h20);
        chk("rf_x14", 64'(rf[14]), 64'h23);

        // Write to x0 is consumed but never enabled.
        step(2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFFFFFF);
        step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("rf_x0", 64'(rf[0]), 64'd0);

        // Reset lands while the x7 write sits in the output stage.
        step(2'b01, 5'd7, 32'h0000AAAA, 5'd0, 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        chk("midrst_wr_en",      64'(wr_en),          64'd0);
        chk("midrst_inflight",   64'(inflight_valid), 64'd0);
        chk("midrst_ready",      64'(req_ready),      64'd0);
        chk("midrst_grant_last", 64'(grant_last),     64'd1);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_gl   = 1'b1;
        m_reg  = 5'd0;
        m_data = 32'd0;
        p_pend = 2'b00;
        chk("rf_x7_dropped", 64'(rf[7]), 64'd0);

        // Post-reset contention on the same register: grant order decides.
        step(2'b11, 5'd20, 32'h1111, 5'd20, 32'h2222);
        step(2'b10, 5'd0, 32'd0, 5'd20, 32'h2222);
        step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("rf_x20_last_wins", 64'(rf[20]), 64'h2222);

`ifdef RF_WR_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++)
            step(2'b11, 5'(k + 1), 32'(32'h30 + k), 5'd21, 32'h77);
        step(2'b10, 5'd0, 32'd0, 5'd21, 32'h77);
        step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("rf_x21_fixed", 64'(rf[21]), 64'h77);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
